// File: rtl/join_sum_n.sv
// N-way join of 2-entry elastic input buffers into an adder, followed by a Stages-deep elastic output pipe.
// Latency is 1+Stages cycles. Every Retry is a flop, so backpressure never crosses a buffer combinationally.
module join_sum_n #(
  parameter int Width = 8,
  parameter int NumIn = 2,
  parameter int Stages = 2,
  parameter int Sat = 0,
  localparam int OutWidth = (Sat != 0) ? Width : Width + $clog2(NumIn)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [NumIn*Width-1:0] inp,
  input  logic [NumIn-1:0]       inpValid,
  output logic [NumIn-1:0]       inpRetry,
  output logic [OutWidth-1:0]    sum,
  output logic                   sumOvf,
  output logic                   sumValid,
  input  logic                   sumRetry
);

  localparam int SumW = Width + $clog2(NumIn);
  localparam int NB = NumIn + Stages;

  logic             flush;
  logic [NumIn-1:0] hd_valid;
  logic [Width-1:0] hd_dat [NumIn];
  logic [OutWidth:0] st_dat [Stages+1];
  logic [Stages:0]   st_valid;
  logic [Stages-1:0] st_retry;
  logic              join_valid;
  logic              join_fire;
  logic [SumW-1:0]   acc;
  logic [OutWidth:0] join_dat;

  assign flush = reset | clear;

  // Buffers 0..NumIn-1 sit on the inputs; the remaining ones form the output pipe.
  for (genvar b = 0; b < NB; b++) begin : g_buf
    localparam int BW = (b < NumIn) ? Width : OutWidth + 1;
    logic [BW-1:0] in_dat;
    logic [BW-1:0] out_dat;
    logic [BW-1:0] mem [2];
    logic          in_valid, in_retry, out_valid, out_retry;
    logic          wr, rd, wr_ptr, rd_ptr;
    logic [1:0]    count, count_next;

    if (b < NumIn) begin : g_in
      assign in_dat      = inp[b*Width +: Width];
      assign in_valid    = inpValid[b];
      assign inpRetry[b] = in_retry;
      assign hd_dat[b]   = out_dat;
      assign hd_valid[b] = out_valid;
      assign out_retry   = ~join_fire;
    end else begin : g_out
      localparam int K = b - NumIn;
      assign in_dat          = st_dat[K];
      assign in_valid        = st_valid[K];
      assign st_retry[K]     = in_retry;
      assign st_dat[K+1]     = out_dat;
      assign st_valid[K+1]   = out_valid;
      if (K == Stages - 1) begin : g_last
        assign out_retry = sumRetry;
      end else begin : g_mid
        assign out_retry = st_retry[K+1];
      end
    end

    assign wr        = in_valid & ~in_retry;
    assign rd        = out_valid & ~out_retry;
    assign out_valid = (count != 2'd0);
    assign out_dat   = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
      count_next = count;
      if (wr && !rd) begin
        count_next = count + 2'd1;
      end else if (rd && !wr) begin
        count_next = count - 2'd1;
      end
    end

    // Retry is the registered "full" state, so a full buffer can never be written.
    always_ff @(posedge clk) begin
      if (flush) begin
        count    <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        in_retry <= 1'b0;
      end else begin
        count    <= count_next;
        in_retry <= (count_next == 2'd2);
        if (wr) wr_ptr <= ~wr_ptr;
        if (rd) rd_ptr <= ~rd_ptr;
      end
    end

    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= in_dat;
    end
  end

  assign join_valid = &hd_valid;
  assign join_fire  = join_valid & ~st_retry[0];

  always_comb begin
    acc = '0;
    for (int i = 0; i < NumIn; i++) begin
      acc = acc + SumW'(hd_dat[i]);
    end
  end

  if (Sat != 0) begin : g_sat
    logic ovf;
    assign ovf      = |acc[SumW-1:Width];
    assign join_dat = {ovf, ovf ? {OutWidth{1'b1}} : acc[OutWidth-1:0]};
  end else begin : g_exact
    assign join_dat = {1'b0, acc};
  end

  assign st_dat[0]   = join_dat;
  assign st_valid[0] = join_valid;

  assign sum      = st_dat[Stages][OutWidth-1:0];
  assign sumOvf   = st_dat[Stages][OutWidth];
  assign sumValid = st_valid[Stages];

endmodule

// File: doc/join_sum_n.md
# join_sum_n

Parametrised N-way join-and-add pipeline on the Valid/Retry elastic protocol. Each of `NumIn` input channels passes through its own 2-entry elastic buffer. A join stage fires only when every channel holds a token, and the unsigned sum of all tokens goes through a configurable-depth elastic output pipeline. The block generalises the fixed two-input, 8-bit join-adder: it adds channel count, data width, pipeline depth, a saturating mode with overflow flag, and a functional flush.

## Interface
- `Width`, 8, bits per input operand.
- `NumIn`, 2, number of input channels; legal 2..16.
- `Stages`, 2, elastic stages after the join; legal 1..8.
- `Sat`, 0, 0 = exact sum, 1 = saturate to `Width` bits.
- `OutWidth`, derived: `Width+$clog2(NumIn)` if `Sat`=0, else `Width`.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous flush of all buffers; same effect as `reset` on datapath state.
- `inp` in `NumIn*Width`: channel i occupies bits `[i*Width +: Width]`.
- `inpValid` in `NumIn`: per-channel valid.
- `inpRetry` out `NumIn`: per-channel backpressure; registered.
- `sum` out `OutWidth`: result.
- `sumOvf` out 1: result was clamped; 0 always when `Sat`=0.
- `sumValid` out 1: result valid.
- `sumRetry` in 1: downstream backpressure.

## Operation
- Transfer on any channel occurs in a cycle where Valid=1 and Retry=0. A producer holding Valid=1 under Retry=1 keeps data stable until transfer.
- Input buffer per channel:
  - 2 entries, FIFO order.
  - `inpRetry[i]` is a flop output: 1 when the buffer is full, or when it holds 1 entry and a write arrives without a same-cycle read.
  - No combinational path from `sumRetry` or any other channel to `inpRetry[i]`.
- Join:
  - `joinValid` = AND of all buffer head-valids.
  - The join stage reads, popping every buffer in the same cycle, only when `joinValid`=1 and the first output stage accepts.
  - No partial pops: a channel with a token waits, without loss, for the others.
- Arithmetic:
  - Zero-extend every operand to `Width+$clog2(NumIn)` and add.
  - `Sat`=0: output the full sum.
  - `Sat`=1: if the sum exceeds `2^Width-1`, output `2^Width-1` with `sumOvf`=1; else output the sum with `sumOvf`=0.
  - `sumOvf` travels through the pipeline with its token.
- Output pipeline:
  - `Stages` chained 2-entry elastic buffers with the same rules as the input buffers.
  - Retry is registered per stage.
  - Order is preserved end to end.
- `reset` or `clear` high in a cycle:
  - Every buffer is emptied at the next edge; tokens in flight are discarded.
  - Inputs presented in that cycle are not accepted.
  - `clear` has no effect on parameters. It only flushes.
- Reset values: `sumValid`=0, `sum`=0, `sumOvf`=0, `inpRetry`=0 (all buffers empty).

## Timing
- Latency from input transfer (last channel to arrive) to `sumValid`=1 is 1+`Stages` cycles with no backpressure. Default is 3 cycles.
- Throughput is one result per cycle with all inputs valid and `sumRetry`=0.
- `sumRetry` asserted:
  - `sumValid`, `sum` and `sumOvf` hold stable.
  - Buffers fill back-to-front.
  - Each `inpRetry[i]` rises at most 1 cycle after its buffer reaches 2 entries.
  - Total tokens absorbed per channel before stalling is 2 + 2×`Stages` + (join is unregistered, 0) minus tokens already held.
- `sumRetry` deasserted: the first new transfer follows in the same cycle (head already valid), and drain proceeds at 1 per cycle.
- Simultaneous pop and push on a full buffer:
  - Legal only if Retry was 0 in that cycle.
  - Because Retry is registered, a buffer never overflows.
- `clear` and `reset` asserted together behave as `reset`.
- `reset` mid-operation: outputs return to reset values one cycle later regardless of backpressure state.

## Test plan
- Defaults: A=3 and B=4 applied together, `sumRetry`=0 -> `sum`=7, `sumValid`=1 exactly 3 cycles after the transfer; the stream 1..100 on both channels yields 2,4,..,200 at one per cycle.
- `NumIn`=4, `Width`=8: channels arrive at cycles 0, 2, 5, 9 with values 255, 255, 255, 255 -> one result `sum`=1020 (10-bit) at cycle 9+3. No earlier `sumValid`. Early channels hold `inpRetry`=0 until their buffers fill.
- Backpressure: hold `sumRetry`=1 for 20 cycles while streaming on both channels -> `sum` stays stable, `inpRetry` rises, no token is lost or duplicated. On release, the output sequence matches the input order exactly.
- `Sat`=1, `Width`=8, `NumIn`=2:
  - 200+100 -> `sum`=255, `sumOvf`=1.
  - 100+100 -> `sum`=200, `sumOvf`=0.
  - 255+0 -> `sum`=255, `sumOvf`=0.
- `clear` pulsed for 1 cycle with 5 tokens in flight and `sumRetry`=1 -> the next cycle shows `sumValid`=0 and `inpRetry`=0. A later new pair 9+1 -> `sum`=10 with no stale result emitted.
- `reset` asserted mid-stream for 3 cycles with Valid held high on all inputs -> nothing is accepted during reset, and outputs read reset values. The first post-reset transfer yields its correct sum 3 cycles later.
